mc_datapath_mul: RTL and testbench

- Parametrised multicycle ARM datapath with an iterative shift-add multiplier for MUL Rd, Rm, Rs.
- Sits between the multicycle controller and the unified instruction/data memory.
- The controller sequences fetch, decode, execute, memory and writeback through the existing control strobes.
- For MUL, the controller issues MulStart and waits for MulDone.

---
 rtl/mc_datapath_mul_pkg.sv | 35 +++
 rtl/mc_datapath_mul_if.sv | 38 +++
 rtl/mc_datapath_mul_mul_iter.sv | 86 ++++++++
 rtl/mc_datapath_mul.sv | 156 +++++++++++++++
 tb/tb_mc_datapath_mul.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_datapath_mul_pkg.sv
// Shared types and constants for the multicycle datapath with iterative multiplier.
// Enumerations name the result/ALU selects and the multiplier sequencer states.
package dp_pkg;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_SHOUT  = 2'b10,
        RES_MUL    = 2'b11
    } result_src_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    localparam int REGSRC_RA1_PC = 0;
    localparam int REGSRC_RA2_RD = 1;
    localparam int REGSRC_MUL    = 2;
    localparam int BYTE_BITS     = 8;

    // PC increment is one word, i.e. WIDTH/8 bytes.
    function automatic int pc_inc(input int width);
        return width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/mc_datapath_mul_if.sv
// Controller/memory-facing bus of the multicycle datapath.
// slave = datapath side, master = controller/memory side.
interface mc_datapath_mul_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Instr;
    logic [2:0]       RegSrc;
    logic             RegWrite;
    logic [1:0]       ImmSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUControl;
    logic             AdrSrc;
    logic             PCWrite;
    logic             IRWrite;
    logic [WIDTH-1:0] Adr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;
    logic [3:0]       ALUFlags;
    logic [1:0]       ResultSrc;
    logic [WIDTH-1:0] ALUResult;
    logic             Shift;
    logic             MulStart;
    logic             MulBusy;
    logic             MulDone;

    modport master (
        input  Instr, Adr, WriteData, ALUFlags, ALUResult, MulBusy, MulDone,
        output RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
               AdrSrc, PCWrite, IRWrite, ReadData, ResultSrc, Shift, MulStart
    );

    modport slave (
        output Instr, Adr, WriteData, ALUFlags, ALUResult, MulBusy, MulDone,
        input  RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
               AdrSrc, PCWrite, IRWrite, ReadData, ResultSrc, Shift, MulStart
    );
endinterface

// File: rtl/mc_datapath_mul_mul_iter.sv
// Iterative shift-add multiplier, MUL_UNROLL multiplier bits retired per cycle.
// Latency: done pulses WIDTH/MUL_UNROLL+1 edges after the start sample edge.
// No backpressure: start is ignored unless idle, done is a single-cycle pulse.
module mul_iter import dp_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int STEPS = WIDTH / MUL_UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);

    mul_state_t       state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc, partial, acc_nxt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= MUL_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_RUN;
            MUL_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = MUL_DONE;
            end
            MUL_DONE: begin
                done      = 1'b1;
                state_nxt = MUL_IDLE;
            end
            default: state_nxt = MUL_IDLE;
        endcase
    end

    // Partial product of the multiplicand with the low MUL_UNROLL multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    assign acc_nxt = acc + partial;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= CNT_W'(STEPS);
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << MUL_UNROLL;
                    mplier <= mplier >> MUL_UNROLL;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) product <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_datapath_mul.sv
// Multicycle ARM datapath with iterative MUL; optional MUL_FLAGS_EN drives NZ from MulOut.
// Latency: one edge per controller step; multiply takes WIDTH/MUL_UNROLL+1 edges to MulDone.
// No backpressure: controller sequences strobes and waits on MulDone; MulStart ignored while busy.
module mc_datapath_mul import dp_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    mc_datapath_mul_if.slave bus
);
    localparam int PC_INC = pc_inc(WIDTH);

    logic [WIDTH-1:0] pc, instr, data, a_reg, b_reg, alu_out, mul_out;
    logic [WIDTH-1:0] result, rd1, rd2, ext_imm, sh_b, src_a, src_b, alu_result, sh_out;
    logic [WIDTH:0]   sum;
    logic [3:0]       ra1, ra2, wa, flags;
    logic [4:0]       shamt;
    logic [1:0]       shtype;
    logic             carry, ovf, mul_busy, mul_done;
    logic [WIDTH-1:0] rf [15];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            instr   <= '0;
            data    <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (bus.PCWrite) pc    <= result;
            if (bus.IRWrite) instr <= bus.ReadData;
            data    <= bus.ReadData;
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_result;
        end
    end

    // R15 is not stored; its reads see Result.
    always_ff @(posedge clk) begin
        if (bus.RegWrite && wa != 4'd15) rf[wa] <= result;
    end

    always_comb begin
        ra1 = bus.RegSrc[REGSRC_RA1_PC] ? 4'd15 : instr[19:16];
        ra2 = bus.RegSrc[REGSRC_RA2_RD] ? instr[15:12] : instr[3:0];
        wa  = instr[15:12];
        if (bus.RegSrc[REGSRC_MUL]) begin
            ra1 = instr[11:8];
            ra2 = instr[3:0];
            wa  = instr[19:16];
        end
    end

    assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
    assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];

    always_comb begin
        case (bus.ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr[11:0]};
            default: ext_imm = {{(WIDTH-26){instr[23]}}, instr[23:0], 2'b00};
        endcase
    end

    assign shamt  = instr[11:7];
    assign shtype = instr[6:5];

    // A zero amount leaves B untouched for every shift type, including ROR.
    always_comb begin
        case (shtype)
            2'b00:   sh_b = b_reg << shamt;
            2'b01:   sh_b = b_reg >> shamt;
            2'b10:   sh_b = $signed(b_reg) >>> shamt;
            default: sh_b = (b_reg >> shamt) | (b_reg << (WIDTH - int'(shamt)));
        endcase
    end

    assign src_a = bus.ALUSrcA ? pc : a_reg;

    always_comb begin
        case (bus.ALUSrcB)
            2'b00:   src_b = sh_b;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = WIDTH'(PC_INC);
            default: src_b = '0;
        endcase
    end

    always_comb begin
        sum        = '0;
        alu_result = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        case (alu_op_t'(bus.ALUControl))
            ALU_ADD: begin
                sum        = {1'b0, src_a} + {1'b0, src_b};
                alu_result = sum[WIDTH-1:0];
                carry      = sum[WIDTH];
                ovf        = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum        = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
                alu_result = sum[WIDTH-1:0];
                carry      = sum[WIDTH];
                ovf        = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_result = src_a & src_b;
            default: alu_result = src_a | src_b;
        endcase
    end

    always_comb begin
        flags = {alu_result[WIDTH-1], alu_result == '0, carry, ovf};
`ifdef MUL_FLAGS_EN
        if (result_src_t'(bus.ResultSrc) == RES_MUL)
            flags = {mul_out[WIDTH-1], mul_out == '0, 2'b00};
`endif
    end

    assign sh_out = bus.Shift ? src_b : alu_result;

    always_comb begin
        case (result_src_t'(bus.ResultSrc))
            RES_ALUOUT: result = alu_out;
            RES_DATA:   result = data;
            RES_SHOUT:  result = sh_out;
            default:    result = mul_out;
        endcase
    end

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_UNROLL (MUL_UNROLL)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bus.MulStart),
        .a       (a_reg),
        .b       (b_reg),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_out)
    );

    assign bus.Instr     = instr;
    assign bus.Adr       = bus.AdrSrc ? result : pc;
    assign bus.WriteData = b_reg;
    assign bus.ALUResult = alu_result;
    assign bus.ALUFlags  = flags;
    assign bus.MulBusy   = mul_busy;
    assign bus.MulDone   = mul_done;

endmodule

// File: tb/tb_mc_datapath_mul.sv
// Bench for mc_datapath_mul: two instances (MUL_UNROLL 1 and 4) share one stimulus stream.
module tb_mc_datapath_mul;
    localparam int W = 32;
    localparam logic [31:0] MUL_INSTR = 32'hE0030192; // MUL R3, R2, R1

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_datapath_mul_if #(.WIDTH(W)) b1 ();
    mc_datapath_mul_if #(.WIDTH(W)) b4 ();

    mc_datapath_mul #(.WIDTH(W), .MUL_UNROLL(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    mc_datapath_mul #(.WIDTH(W), .MUL_UNROLL(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));

    assign b4.RegSrc     = b1.RegSrc;
    assign b4.RegWrite   = b1.RegWrite;
    assign b4.ImmSrc     = b1.ImmSrc;
    assign b4.ALUSrcA    = b1.ALUSrcA;
    assign b4.ALUSrcB    = b1.ALUSrcB;
    assign b4.ALUControl = b1.ALUControl;
    assign b4.AdrSrc     = b1.AdrSrc;
    assign b4.PCWrite    = b1.PCWrite;
    assign b4.IRWrite    = b1.IRWrite;
    assign b4.ReadData   = b1.ReadData;
    assign b4.ResultSrc  = b1.ResultSrc;
    assign b4.Shift      = b1.Shift;
    assign b4.MulStart   = b1.MulStart;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference shifter from the shift-type definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input int ty);
        case (ty)
            0:       return v << n;
            1:       return v >> n;
            2:       return $signed(v) >>> n;
            default: return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
        endcase
    endfunction

    // Reference ALU: {N,Z,C,V,result} from wide integer arithmetic.
    function automatic logic [35:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input int op);
        longint ux, uy, sx, sy, sfull;
        logic [31:0] r;
        logic c, v;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin
                r = x + y;
                c = (ux + uy) > 64'hFFFF_FFFF;
                sfull = sx + sy;
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            1: begin
                r = x - y;
                c = (ux >= uy);
                sfull = sx - sy;
                v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            2:       r = x & y;
            default: r = x | y;
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    task automatic load_instr(input logic [31:0] ins);
        b1.ReadData = ins;
        b1.IRWrite  = 1'b1;
        tick();
        b1.IRWrite  = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
        b1.RegSrc = 3'b000;
        load_instr({16'h0000, r, 12'h000});
        b1.ReadData  = v;
        b1.ResultSrc = 2'b01;
        tick();
        b1.RegWrite = 1'b1;
        tick();
        b1.RegWrite = 1'b0;
    endtask

    task automatic alu_case(input logic [31:0] x, input logic [31:0] y, input int amt, input int ty, input int op);
        logic [35:0] e;
        write_reg(4'd1, x);
        write_reg(4'd2, y);
        load_instr({12'hE00, 4'd1, 4'd3, 5'(amt), 2'(ty), 1'b0, 4'd2});
        b1.RegSrc = 3'b000; b1.ALUSrcA = 1'b0; b1.ALUSrcB = 2'b00;
        b1.ALUControl = 2'(op); b1.ResultSrc = 2'b00;
        tick();
        e = ref_alu(x, ref_shift(y, amt, ty), op);
        chk("alu_result", b1.ALUResult, e[31:0]);
        chk("alu_flags", 32'(b1.ALUFlags), 32'(e[35:32]));
    endtask

    task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input bit restart);
        int busy1 = 0, busy4 = 0, done1 = 0, done4 = 0, first1 = 0, first4 = 0;
        logic [31:0] p;
        write_reg(4'd1, x);
        write_reg(4'd2, y);
        load_instr(MUL_INSTR);
        b1.RegSrc = 3'b100;
        tick();
        chk("mul_b_operand", b1.WriteData, y);
        b1.MulStart = 1'b1;
        tick();
        b1.MulStart = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (b1.MulBusy) busy1++;
            if (b4.MulBusy) busy4++;
            if (b1.MulDone) begin done1++; if (first1 == 0) first1 = k; end
            if (b4.MulDone) begin done4++; if (first4 == 0) first4 = k; end
            b1.MulStart = restart && (k == 3);
            tick();
        end
        b1.MulStart = 1'b0;
        p = x * y;
        chk("u1_busy_cycles", 32'(busy1), 32'd32);
        chk("u1_done_cycle", 32'(first1), 32'd33);
        chk("u1_done_count", 32'(done1), 32'd1);
        chk("u4_busy_cycles", 32'(busy4), 32'd8);
        chk("u4_done_cycle", 32'(first4), 32'd9);
        chk("u4_done_count", 32'(done4), 32'd1);
        b1.ResultSrc = 2'b11;
        b1.AdrSrc    = 1'b1;
        #1;
        chk("u1_mulout", b1.Adr, p);
        chk("u4_mulout", b4.Adr, p);
        b1.AdrSrc = 1'b0;
    endtask

    initial begin
        logic [31:0] x;
        logic [35:0] e;
        int d1, d4;
        reset_n = 1'b0;
        b1.RegSrc = '0; b1.RegWrite = 0; b1.ImmSrc = '0; b1.ALUSrcA = 0; b1.ALUSrcB = '0;
        b1.ALUControl = '0; b1.AdrSrc = 0; b1.PCWrite = 0; b1.IRWrite = 0; b1.ReadData = '0;
        b1.ResultSrc = '0; b1.Shift = 0; b1.MulStart = 0;
        tick(); tick();
        chk("rst_instr", b1.Instr, 32'd0);
        chk("rst_b", b1.WriteData, 32'd0);
        chk("rst_pc", b1.Adr, 32'd0);
        chk("rst_busy", 32'(b1.MulBusy), 32'd0);
        chk("rst_done", 32'(b4.MulDone), 32'd0);
        reset_n = 1'b1;
        tick();

        // Fetch: PC+4 through ShOut, IR load.
        b1.ReadData = 32'hE0810002; b1.IRWrite = 1; b1.PCWrite = 1; b1.ALUSrcA = 1;
        b1.ALUSrcB = 2'b10; b1.ALUControl = 2'b00; b1.ResultSrc = 2'b10; b1.Shift = 0;
        #1;
        chk("fetch_adr_before", b1.Adr, 32'd0);
        tick();
        b1.IRWrite = 0; b1.PCWrite = 0;
        chk("fetch_instr", b1.Instr, 32'hE0810002);
        chk("fetch_adr_after", b1.Adr, 32'd4);

        // ADD R3, R1, R2 LSL 3 with R1=1, R2=2.
        alu_case(32'd1, 32'd2, 3, 0, 0);
        chk("add_lsl3", b1.ALUResult, 32'd17);
        chk("add_lsl3_flags", 32'(b1.ALUFlags), 32'h0);
        x = $urandom;
        alu_case(x, x, 0, 0, 1);
        chk("sub_equal_flags", 32'(b1.ALUFlags), 32'h6);
        alu_case(32'h7FFF_FFFF, 32'd1, 0, 0, 0);
        alu_case(32'h8000_0000, 32'd1, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            alu_case($urandom, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));

        run_mul(32'd7, 32'd6, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++)
            run_mul($urandom, $urandom, 1'($urandom_range(0, 1)));

        // Reset in the middle of a UNROLL=1 multiply.
        write_reg(4'd1, 32'd3);
        write_reg(4'd2, 32'd5);
        load_instr(MUL_INSTR);
        b1.RegSrc = 3'b100;
        tick();
        b1.MulStart = 1'b1;
        tick();
        b1.MulStart = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("pre_reset_busy", 32'(b1.MulBusy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(b1.MulBusy), 32'd0);
        chk("arst_instr", b1.Instr, 32'd0);
        chk("arst_b", b1.WriteData, 32'd0);
        chk("arst_pc", b1.Adr, 32'd0);
        b1.ResultSrc = 2'b11; b1.AdrSrc = 1'b1;
        #1;
        chk("arst_u1_mulout", b1.Adr, 32'd0);
        chk("arst_u4_mulout", b4.Adr, 32'd0);
        b1.AdrSrc = 1'b0;
        tick();
        reset_n = 1'b1;
        d1 = 0; d4 = 0;
        for (int k = 0; k < 40; k++) begin
            if (b1.MulDone || b1.MulBusy) d1++;
            if (b4.MulDone || b4.MulBusy) d4++;
            tick();
        end
        chk("post_reset_u1_quiet", 32'(d1), 32'd0);
        chk("post_reset_u4_quiet", 32'(d4), 32'd0);

        // 0 x 9 then flags with ResultSrc=MulOut; PC is 0 after the reset.
        run_mul(32'd0, 32'd9, 1'b0);
        b1.ResultSrc = 2'b11; b1.ALUSrcA = 1'b1; b1.ALUSrcB = 2'b01;
        b1.ImmSrc = 2'b00; b1.ALUControl = 2'b11;
        #1;
`ifdef MUL_FLAGS_EN
        e = {4'b0100, 32'd0};
`else
        e = ref_alu(32'd0, 32'h0000_0092, 3);
`endif
        chk("mul_flags_u1", 32'(b1.ALUFlags), 32'(e[35:32]));
        chk("mul_flags_u4", 32'(b4.ALUFlags), 32'(e[35:32]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
